ahb_periph_ctrl: RTL and testbench
==================================

Name: ahb_periph_ctrl

Overview:
- Parametrised AHB-Lite slave register block; successor to the single-LED/scratch ISP controller.
- Provides NUM_OUT general output registers, a synchronised input port with sticky edge capture and interrupt, and NUM_PWM independent PWM generators with shadowed period/duty.
- Sits on the AHB peripheral decode as a zero-wait-state slave.
- Unlike its predecessor, it implements proper address/data-phase pipelining, byte-lane writes and a read-data path aligned to the data phase.

Parameters:
- NUM_OUT, 4, number of 32-bit output registers (1..16)
- NUM_PWM, 2, number of PWM channels (1..8)
- IN_W, 16, width of input port GPI (1..32)
- PWM_W, 32, width of PWM period/duty/counter (8..32)
- ID_VALUE, 32'h1502_0001, constant returned at offset 0x000

Ports:
- HCLK  in  1  system bus clock; all logic on rising edge
- HRESET  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HREADY  in  1  bus ready in
- HTRANS  in  2  transfer type; bit1 = NONSEQ/SEQ
- HSIZE  in  3  transfer size (0 byte, 1 half, 2 word)
- HWRITE  in  1  write direction
- HADDR  in  12  byte address
- HWDATA  in  32  write data (data phase)
- HREADYOUT  out  1  constant 1
- HRESP  out  1  constant 0 (OKAY)
- HRDATA  out  32  read data (data phase)
- GPI  in  IN_W  asynchronous general inputs
- OUT_BUS  out  NUM_OUT*32  concatenated output registers; reg i at [32i+31:32i]
- PWM_OUT  out  NUM_PWM  registered PWM outputs
- IRQ  out  1  registered level interrupt

Behaviour:
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register dp_valid=1, dp_write=HWRITE, dp_addr=HADDR[11:2] and a 4-bit byte mask:
  - HSIZE=0: lane HADDR[1:0]
  - HSIZE=1: lanes {HADDR[1],0} and {HADDR[1],1}
  - HSIZE>=2: all four lanes
- When not accepted, dp_valid=0.
- Writes commit at the end of the data phase (dp_valid & dp_write) using HWDATA and the byte mask. Unmapped offsets ignore writes.
- HRDATA is combinational from dp_addr when dp_valid & ~dp_write, else 0. Unmapped offsets read 0. Zero wait states.
- A read immediately following a write to the same register returns the new value.
- Register map (word offsets; reserved bits read 0):
  - 0x000 ID, R: ID_VALUE
  - 0x004 IN_DATA, R: synchronised GPI
  - 0x008 IN_EDGE, R/W1C: sticky rising-edge flags
  - 0x00C IRQ_EN, RW: [IN_W-1:0]
  - 0x010+4i OUT_REG[i], RW, for i<NUM_OUT
  - 0x100+8j PWM_PERIOD[j], RW, for j<NUM_PWM; upper bits above PWM_W ignored / read 0
  - 0x104+8j PWM_DUTY[j], RW, same width rule
- Inputs: 2-flop synchroniser, then a previous-value flop. Rising edge = sync & ~prev. GPI-to-IN_DATA latency is 2 cycles; edge flag sets 1 cycle later.
- IN_EDGE: a bit sets on its edge and clears on a W1C write of 1. A simultaneous edge and clear leaves the bit set.
- IRQ is registered: IRQ <= |(IN_EDGE & IRQ_EN), one cycle behind the flag.
- PWM channel j:
  - PWM_PERIOD/PWM_DUTY writes go to shadow registers.
  - Active period/duty load from shadow when cnt == act_period-1 (wrap), or whenever act_period == 0.
  - cnt runs 0..act_period-1 and wraps to 0; it is held at 0 when act_period == 0.
  - PWM_OUT[j] <= (act_period != 0) & (cnt < act_duty).
  - duty >= period gives constant 1; duty == 0 gives constant 0.
- Reset (HRESET high at a clock edge): all registers, shadows, counters, sync flops, dp_valid, PWM_OUT and IRQ go to 0. OUT_BUS=0 and HRDATA=0 the next cycle.
- Reset mid-transfer discards the pending data phase with no write.

Test Plan:
- After reset, word read 0x000 → HRDATA=ID_VALUE in the data phase. Read 0x010 → 0. PWM_OUT=0, IRQ=0.
- Word write 0xDEADBEEF to 0x014, then byte write 0x55 at 0x016 (HSIZE=0), then read 0x014 → 0xDE55BEEF. Back-to-back write-then-read returns the new value.
- GPI[3] 0→1 with IRQ_EN=0x8 → IN_EDGE=0x8 three cycles after the input edge, IRQ=1 one cycle later. W1C 0x8 coincident with a new GPI[3] edge → bit stays 1.
- PWM0 period=4, duty=1 → PWM_OUT[0] is periodic 1,0,0,0. Write duty=3 mid-period → change appears only after the next wrap. Period=0 → output constant 0.
- Write to 0x0F0 (unmapped) then read it → 0, no other register changes, HRESP=0, HREADYOUT=1 throughout.
- Assert HRESET during the data phase of a write to 0x010 → OUT_REG[0]=0 after reset, no write committed.

Source files
------------

// File: rtl/ahb_periph_ctrl.sv
// AHB-Lite zero-wait-state peripheral register block: ID, synchronised
// input port with sticky rising-edge capture and interrupt, general output
// registers, and independent PWM channels with shadowed period/duty.
module ahb_periph_ctrl #(
   parameter int unsigned NUM_OUT  = 4,
   parameter int unsigned NUM_PWM  = 2,
   parameter int unsigned IN_W     = 16,
   parameter int unsigned PWM_W    = 32,
   parameter logic [31:0] ID_VALUE = 32'h1502_0001
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   HSEL,
   input  logic                   HREADY,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HSIZE,
   input  logic                   HWRITE,
   input  logic [11:0]            HADDR,
   input  logic [31:0]            HWDATA,
   output logic                   HREADYOUT,
   output logic                   HRESP,
   output logic [31:0]            HRDATA,
   input  logic [IN_W-1:0]        GPI,
   output logic [NUM_OUT*32-1:0]  OUT_BUS,
   output logic [NUM_PWM-1:0]     PWM_OUT,
   output logic                   IRQ
);

   // Word offsets (HADDR[11:2]) of the register map.
   localparam logic [9:0] A_ID       = 10'h000;
   localparam logic [9:0] A_IN_DATA  = 10'h001;
   localparam logic [9:0] A_IN_EDGE  = 10'h002;
   localparam logic [9:0] A_IRQ_EN   = 10'h003;
   localparam logic [9:0] A_OUT_BASE = 10'h004;
   localparam logic [9:0] A_PWM_BASE = 10'h040;

   // Data-phase state captured from the address phase.
   logic        dp_valid;
   logic        dp_write;
   logic [9:0]  dp_addr;
   logic [3:0]  dp_mask;
   logic [3:0]  ap_mask;
   logic        ap_accept;
   logic        wr_en;
   logic [31:0] wmask;

   // Register storage.
   logic [IN_W-1:0]  sync1, sync2, sync_prev;
   logic [IN_W-1:0]  in_rise, in_edge, in_edge_clr, irq_en;
   logic [31:0]      out_reg    [NUM_OUT];
   logic [PWM_W-1:0] sh_period  [NUM_PWM];
   logic [PWM_W-1:0] sh_duty    [NUM_PWM];
   logic [PWM_W-1:0] act_period [NUM_PWM];
   logic [PWM_W-1:0] act_duty   [NUM_PWM];
   logic [PWM_W-1:0] cnt        [NUM_PWM];
   logic [NUM_PWM-1:0] pwm_zero, pwm_wrap;

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

   // NONSEQ (2'b10) or SEQ (2'b11) marks a real transfer.
   assign ap_accept = HSEL && HREADY && ((HTRANS == 2'b10) || (HTRANS == 2'b11));
   assign wr_en     = dp_valid && dp_write;
   assign wmask     = {{8{dp_mask[3]}}, {8{dp_mask[2]}}, {8{dp_mask[1]}}, {8{dp_mask[0]}}};
   assign in_rise   = sync2 & ~sync_prev;

   // Byte-lane mask for the transfer being presented in the address phase.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      ap_mask = 4'b1111;
      case (HSIZE)
         3'd0:    ap_mask = 4'b0001 << HADDR[1:0];
         3'd1:    ap_mask = HADDR[1] ? 4'b1100 : 4'b0011;
         default: ap_mask = 4'b1111;
      endcase
   end

   // Address phase -> data phase pipeline register.
   always_ff @(posedge HCLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (HRESET) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         dp_mask  <= '0;
      end else begin
         dp_valid <= ap_accept;
         dp_write <= HWRITE;
         dp_addr  <= HADDR[11:2];
         dp_mask  <= ap_mask;
      end
   end

   // Two-flop synchroniser followed by the previous-value flop for edge detect.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         sync1     <= '0;
         sync2     <= '0;
         sync_prev <= '0;
      end else begin
         sync1     <= GPI;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   // W1C clear vector for IN_EDGE from the committing write.
   always_comb begin
      in_edge_clr = '0;
      if (wr_en && (dp_addr == A_IN_EDGE)) in_edge_clr = IN_W'(HWDATA & wmask);
   end

   // Sticky edge flags (a new edge wins over a clear) and the registered interrupt.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         in_edge <= '0;
         IRQ     <= 1'b0;
      end else begin
         in_edge <= (in_edge & ~in_edge_clr) | in_rise;
         IRQ     <= |(in_edge & irq_en);
      end
   end

   // Bus-writable registers: IRQ enable, output registers, PWM shadows.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         // NOTE: these arrays are small flop banks with a defined reset value, so they are reset like any other register.
         irq_en <= '0;
         for (int i = 0; i < NUM_OUT; i++) out_reg[i] <= '0;
         for (int j = 0; j < NUM_PWM; j++) begin
            sh_period[j] <= '0;
            sh_duty[j]   <= '0;
         end
      end else if (wr_en) begin
         if (dp_addr == A_IRQ_EN)
            irq_en <= IN_W'((32'(irq_en) & ~wmask) | (HWDATA & wmask));
         for (int i = 0; i < NUM_OUT; i++)
            if (dp_addr == A_OUT_BASE + 10'(i))
               out_reg[i] <= (out_reg[i] & ~wmask) | (HWDATA & wmask);
         for (int j = 0; j < NUM_PWM; j++) begin
            if (dp_addr == A_PWM_BASE + 10'(2 * j))
               sh_period[j] <= PWM_W'((32'(sh_period[j]) & ~wmask) | (HWDATA & wmask));
            if (dp_addr == A_PWM_BASE + 10'(2 * j + 1))
               sh_duty[j] <= PWM_W'((32'(sh_duty[j]) & ~wmask) | (HWDATA & wmask));
         end
      end
   end

   // Per-channel wrap and idle detection.
   always_comb begin
      pwm_zero = '0;
      pwm_wrap = '0;
      for (int j = 0; j < NUM_PWM; j++) begin
         pwm_zero[j] = (act_period[j] == '0);
         pwm_wrap[j] = (cnt[j] == act_period[j] - PWM_W'(1));
      end
   end

   // PWM counters: active settings reload from shadows at wrap or while idle.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         PWM_OUT <= '0;
         for (int j = 0; j < NUM_PWM; j++) begin
            act_period[j] <= '0;
            act_duty[j]   <= '0;
            cnt[j]        <= '0;
         end
      end else begin
         for (int j = 0; j < NUM_PWM; j++) begin
            if (pwm_zero[j] || pwm_wrap[j]) begin
               act_period[j] <= sh_period[j];
               act_duty[j]   <= sh_duty[j];
            end
            cnt[j]     <= (pwm_zero[j] || pwm_wrap[j]) ? '0 : cnt[j] + PWM_W'(1);
            PWM_OUT[j] <= !pwm_zero[j] && (cnt[j] < act_duty[j]);
         end
      end
   end

   // Read-data mux, valid only during a read data phase.
   always_comb begin
      HRDATA = '0;
      if (dp_valid && !dp_write) begin
         if (dp_addr == A_ID)      HRDATA = ID_VALUE;
         if (dp_addr == A_IN_DATA) HRDATA = 32'(sync2);
         if (dp_addr == A_IN_EDGE) HRDATA = 32'(in_edge);
         if (dp_addr == A_IRQ_EN)  HRDATA = 32'(irq_en);
         for (int i = 0; i < NUM_OUT; i++)
            if (dp_addr == A_OUT_BASE + 10'(i)) HRDATA = out_reg[i];
         for (int j = 0; j < NUM_PWM; j++) begin
            if (dp_addr == A_PWM_BASE + 10'(2 * j))     HRDATA = 32'(sh_period[j]);
            if (dp_addr == A_PWM_BASE + 10'(2 * j + 1)) HRDATA = 32'(sh_duty[j]);
         end
      end
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      assign OUT_BUS[32*g +: 32] = out_reg[g];
   end

endmodule

// File: tb/tb_ahb_periph_ctrl.sv
// Self-checking bench for ahb_periph_ctrl: table of bus transfers plus
// hand-written sequences for pipelining, input edges/IRQ, PWM and reset.
module tb_ahb_periph_ctrl;

   logic         HCLK = 1'b0;
   logic         HRESET, HSEL, HREADY, HWRITE;
   logic [1:0]   HTRANS;
   logic [2:0]   HSIZE;
   logic [11:0]  HADDR;
   logic [31:0]  HWDATA, HRDATA;
   logic         HREADYOUT, HRESP, IRQ;
   logic [15:0]  GPI;
   logic [127:0] OUT_BUS;
   logic [1:0]   PWM_OUT;

   int checks   = 0;
   int failures = 0;

   ahb_periph_ctrl dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR),
      .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .GPI(GPI), .OUT_BUS(OUT_BUS), .PWM_OUT(PWM_OUT), .IRQ(IRQ)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        wr;
      logic [2:0]  sz;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
   endtask

   // One isolated transfer: address phase, data phase, then idle.
   task automatic bus_op(input logic wr, input logic [2:0] sz, input logic [11:0] a,
                         input logic [31:0] wd, output logic [31:0] rd);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HADDR = a;
      step();
      bus_idle();
      HWDATA = wd;
      rd = HRDATA;
      check("hresp", HRESP, 32'd0);
      check("hreadyout", HREADYOUT, 32'd1);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        found;
      logic        pat_a [8];
      logic        pat_b [8];

      vecs[0]  = '{1'b0, 3'd2, 12'h000, 32'h0000_0000, 1'b1, 32'h1502_0001};
      vecs[1]  = '{1'b0, 3'd2, 12'h010, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[2]  = '{1'b0, 3'd2, 12'h004, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[3]  = '{1'b1, 3'd2, 12'h014, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      vecs[4]  = '{1'b1, 3'd0, 12'h016, 32'h0055_0000, 1'b0, 32'h0000_0000};
      vecs[5]  = '{1'b0, 3'd2, 12'h014, 32'h0000_0000, 1'b1, 32'hDE55_BEEF};
      vecs[6]  = '{1'b1, 3'd1, 12'h012, 32'h1234_0000, 1'b0, 32'h0000_0000};
      vecs[7]  = '{1'b1, 3'd0, 12'h010, 32'h0000_00AB, 1'b0, 32'h0000_0000};
      vecs[8]  = '{1'b0, 3'd2, 12'h010, 32'h0000_0000, 1'b1, 32'h1234_00AB};
      vecs[9]  = '{1'b1, 3'd1, 12'h014, 32'hFFFF_1111, 1'b0, 32'h0000_0000};
      vecs[10] = '{1'b0, 3'd2, 12'h014, 32'h0000_0000, 1'b1, 32'hDE55_1111};
      vecs[11] = '{1'b1, 3'd2, 12'h0F0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
      vecs[12] = '{1'b0, 3'd2, 12'h0F0, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[13] = '{1'b0, 3'd2, 12'h014, 32'h0000_0000, 1'b1, 32'hDE55_1111};
      vecs[14] = '{1'b0, 3'd2, 12'h010, 32'h0000_0000, 1'b1, 32'h1234_00AB};
      vecs[15] = '{1'b1, 3'd2, 12'h00C, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
      vecs[16] = '{1'b0, 3'd2, 12'h00C, 32'h0000_0000, 1'b1, 32'h0000_FFFF};
      vecs[17] = '{1'b1, 3'd2, 12'h10C, 32'h0000_A5A5, 1'b0, 32'h0000_0000};
      vecs[18] = '{1'b0, 3'd2, 12'h10C, 32'h0000_0000, 1'b1, 32'h0000_A5A5};
      vecs[19] = '{1'b1, 3'd2, 12'h00C, 32'h0000_0008, 1'b0, 32'h0000_0000};
      vecs[20] = '{1'b0, 3'd2, 12'h00C, 32'h0000_0000, 1'b1, 32'h0000_0008};
      vecs[21] = '{1'b0, 3'd2, 12'h008, 32'h0000_0000, 1'b1, 32'h0000_0000};

      pat_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      pat_b = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      HRESET = 1'b1; HREADY = 1'b1; HSIZE = 3'd2; HADDR = '0; HWDATA = '0; GPI = '0;
      bus_idle();
      repeat (3) step();
      HRESET = 1'b0;
      step();

      // Reset state.
      check("rst_hrdata", HRDATA, 32'd0);
      check("rst_out0", OUT_BUS[31:0], 32'd0);
      check("rst_out3", OUT_BUS[127:96], 32'd0);
      check("rst_pwm", 32'(PWM_OUT), 32'd0);
      check("rst_irq", IRQ, 32'd0);

      // Table-driven register transfers.
      for (int k = 0; k < 22; k++) begin
         bus_op(vecs[k].wr, vecs[k].sz, vecs[k].addr, vecs[k].wdata, rd);
         if (vecs[k].chk) check($sformatf("vec%0d_rd_%h", k, vecs[k].addr), rd, vecs[k].exp);
      end
      check("outbus_reg0", OUT_BUS[31:0], 32'h1234_00AB);
      check("outbus_reg1", OUT_BUS[63:32], 32'hDE55_1111);
      check("outbus_reg2", OUT_BUS[95:64], 32'd0);

      // Back-to-back write then read of the same register.
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 12'h018;
      step();
      HWDATA = 32'h0BAD_F00D; HWRITE = 1'b0;
      step();
      bus_idle();
      check("b2b_rd", HRDATA, 32'h0BAD_F00D);
      check("b2b_outbus", OUT_BUS[95:64], 32'h0BAD_F00D);
      step();

      // GPI[3] rising edge: IN_DATA after 2 cycles, flag 1 later, IRQ 1 after that.
      GPI = 16'h0008;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 12'h004;
      step();
      check("in_data_lat1", HRDATA, 32'd0);
      step();
      check("in_data_lat2", HRDATA, 32'h8);
      HADDR = 12'h008;
      step();
      bus_idle();
      check("in_edge_set", HRDATA, 32'h8);
      check("irq_lag", IRQ, 32'd0);
      step();
      check("irq_set", IRQ, 32'd1);

      // Clear coincident with a fresh edge keeps the flag set.
      GPI = 16'h0000;
      repeat (4) step();
      bus_op(1'b0, 3'd2, 12'h008, 32'd0, rd);
      check("in_edge_sticky", rd, 32'h8);
      GPI = 16'h0008;
      step();
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 12'h008;
      step();
      bus_idle();
      HWDATA = 32'h8;
      step();
      bus_op(1'b0, 3'd2, 12'h008, 32'd0, rd);
      check("w1c_vs_edge", rd, 32'h8);
      bus_op(1'b1, 3'd2, 12'h008, 32'h8, rd);
      bus_op(1'b0, 3'd2, 12'h008, 32'd0, rd);
      check("w1c_clear", rd, 32'd0);
      step();
      check("irq_clear", IRQ, 32'd0);

      // PWM0 period 4 duty 1.
      bus_op(1'b1, 3'd2, 12'h100, 32'd4, rd);
      bus_op(1'b1, 3'd2, 12'h104, 32'd1, rd);
      found = 1'b0;
      for (int c = 0; c < 16 && !found; c++) begin
         step();
         found = PWM_OUT[0];
      end
      check("pwm_found_high", found, 32'd1);
      for (int c = 1; c < 8; c++) begin
         step();
         check($sformatf("pwm_d1_%0d", c), PWM_OUT[0], pat_a[c]);
      end

      // Duty 3 written mid-period takes effect only after the wrap.
      bus_op(1'b1, 3'd2, 12'h104, 32'd3, rd);
      check("pwm_d3_0", PWM_OUT[0], pat_b[0]);
      for (int c = 1; c < 8; c++) begin
         step();
         check($sformatf("pwm_d3_%0d", c), PWM_OUT[0], pat_b[c]);
      end
      check("pwm1_idle", PWM_OUT[1], 32'd0);

      // Period 0 forces constant 0.
      bus_op(1'b1, 3'd2, 12'h100, 32'd0, rd);
      repeat (8) step();
      for (int c = 0; c < 6; c++) begin
         check($sformatf("pwm_p0_%0d", c), PWM_OUT[0], 32'd0);
         step();
      end

      // Reset asserted during the data phase of a write to 0x010.
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 12'h010;
      step();
      bus_idle();
      HWDATA = 32'hCAFE_F00D;
      HRESET = 1'b1;
      step();
      HRESET = 1'b0;
      check("rst_mid_out0", OUT_BUS[31:0], 32'd0);
      check("rst_mid_hrdata", HRDATA, 32'd0);
      step();
      bus_op(1'b0, 3'd2, 12'h010, 32'd0, rd);
      check("rst_mid_rd", rd, 32'd0);
      check("rst_mid_out1", OUT_BUS[63:32], 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
